// File: rtl/fp_div_seq.sv
`timescale 1ns/1ps
// fp_div_seq -- sequential IEEE-754 single-precision divider.
//
// Computes fp_Z = fp_X / fp_Y with a restoring divider producing one
// quotient bit per clock, followed by a single rounding cycle.
// Subnormal operands are flushed to signed zero, and results are never
// subnormal (they flush to signed zero with udrf set).
//
// Ports:
//   clk    in   clock, all state changes on the rising edge
//   rst    in   synchronous active-high reset
//   start  in   begin a divide (only honoured while busy=0)
//   fp_X   in   [31:0] dividend
//   fp_Y   in   [31:0] divisor
//   r_mode in   [2:0] rounding: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM, others RNE
//   busy   out  operation in progress
//   done   out  one-cycle pulse, result outputs valid
//   fp_Z   out  [31:0] quotient (held until the next done)
//   ovrf   out  overflow flag of the last result
//   udrf   out  underflow flag of the last result
module fp_div_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] fp_X,
  input  logic [31:0] fp_Y,
  input  logic [2:0]  r_mode,
  output logic        busy,
  output logic        done,
  output logic [31:0] fp_Z,
  output logic        ovrf,
  output logic        udrf
);

  localparam logic [2:0] MODE_RNE = 3'd0;
  localparam logic [2:0] MODE_RTZ = 3'd1;
  localparam logic [2:0] MODE_RDN = 3'd2;
  localparam logic [2:0] MODE_RUP = 3'd3;
  localparam logic [2:0] MODE_RMM = 3'd4;

  typedef enum logic [1:0] {IDLE, DIV, ROUND, DONE} state_t;

  state_t             state;
  logic               sign_reg;
  logic [2:0]         mode_reg;
  logic signed [9:0]  exp_reg;
  logic [24:0]        rem_reg;
  logic [23:0]        div_reg;
  // Holds the last 25 quotient bits: the leading 1 shifts out, leaving
  // 23 fraction bits, guard and round.
  logic [24:0]        q_reg;
  logic [4:0]         cnt_reg;

  // ---------------- operand decode (used in IDLE) ----------------
  logic [7:0]  x_exp, y_exp;
  logic [22:0] x_frac, y_frac;
  logic        x_zero, y_zero, x_inf, y_inf, x_nan, y_nan;
  logic        is_nan, is_inf, is_zero, special;
  logic        sign_in;
  logic [31:0] special_z;
  logic [23:0] mx, my;
  logic        x_lt_y;
  logic [9:0]  exp_init;
  logic [24:0] rem_init;
  logic [2:0]  mode_in;

  always_comb begin
    x_exp   = fp_X[30:23];
    y_exp   = fp_Y[30:23];
    x_frac  = fp_X[22:0];
    y_frac  = fp_Y[22:0];
    x_zero  = (x_exp == 8'h00);
    y_zero  = (y_exp == 8'h00);
    x_inf   = (x_exp == 8'hFF) && (x_frac == 23'd0);
    y_inf   = (y_exp == 8'hFF) && (y_frac == 23'd0);
    x_nan   = (x_exp == 8'hFF) && (x_frac != 23'd0);
    y_nan   = (y_exp == 8'hFF) && (y_frac != 23'd0);
    sign_in = fp_X[31] ^ fp_Y[31];

    // NaN takes precedence; the inf and zero groups are then disjoint.
    is_nan  = x_nan || y_nan || (x_zero && y_zero) || (x_inf && y_inf);
    is_inf  = x_inf || y_zero;
    is_zero = x_zero || y_inf;
    special = is_nan || is_inf || is_zero;

    if (is_nan)
      special_z = 32'h7FC00000;
    else if (is_inf)
      special_z = {sign_in, 8'hFF, 23'd0};
    else
      special_z = {sign_in, 31'd0};

    mx     = {1'b1, x_frac};
    my     = {1'b1, y_frac};
    x_lt_y = (mx < my);
    // Doubling the dividend when it is the smaller mantissa keeps the
    // quotient in [1,2); the exponent compensates by one.
    exp_init = {2'b00, x_exp} - {2'b00, y_exp} + 10'd127 - {9'd0, x_lt_y};
    rem_init = x_lt_y ? {mx, 1'b0} : {1'b0, mx};

    mode_in = (r_mode > MODE_RMM) ? MODE_RNE : r_mode;
  end

  // ---------------- one restoring division step ----------------
  logic        q_bit;
  logic [24:0] rem_step;

  always_comb begin
    q_bit = (rem_reg >= {1'b0, div_reg});
    // The partial remainder is always below the divisor (< 2^24) after the
    // subtract, so the left shift cannot lose a set bit.
    rem_step = (q_bit ? (rem_reg - {1'b0, div_reg}) : rem_reg) << 1;
  end

  // ---------------- rounding ----------------
  logic              g_bit, r_bit, s_bit, lsb, inexact, inc;
  logic [22:0]       frac_sum;
  logic              carry;
  logic signed [9:0] exp_rnd;
  logic              ovf, unf, inf_sel;
  logic [31:0]       round_z;

  always_comb begin
    g_bit   = q_reg[1];
    r_bit   = q_reg[0];
    s_bit   = (rem_reg != 25'd0);
    lsb     = q_reg[2];
    inexact = g_bit | r_bit | s_bit;

    case (mode_reg)
      MODE_RTZ: inc = 1'b0;
      MODE_RDN: inc = sign_reg & inexact;
      MODE_RUP: inc = ~sign_reg & inexact;
      MODE_RMM: inc = g_bit;
      default:  inc = g_bit & (r_bit | s_bit | lsb);
    endcase

    // The hidden 1 is always set, so a carry out of the fraction means the
    // mantissa rolled over to 2.0: fraction is already zero, bump exponent.
    {carry, frac_sum} = {1'b0, q_reg[24:2]} + {23'd0, inc};
    exp_rnd = exp_reg + {9'd0, carry};

    ovf = (exp_rnd >= 10'sd255);
    unf = (exp_rnd <= 10'sd0);

    case (mode_reg)
      MODE_RTZ: inf_sel = 1'b0;
      MODE_RDN: inf_sel = sign_reg;
      MODE_RUP: inf_sel = ~sign_reg;
      default:  inf_sel = 1'b1;
    endcase

    if (ovf)
      round_z = inf_sel ? {sign_reg, 8'hFF, 23'd0} : {sign_reg, 8'hFE, 23'h7FFFFF};
    else if (unf)
      round_z = {sign_reg, 31'd0};
    else
      round_z = {sign_reg, exp_rnd[7:0], frac_sum};
  end

  // ---------------- control FSM with registered outputs ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      fp_Z     <= 32'd0;
      ovrf     <= 1'b0;
      udrf     <= 1'b0;
      sign_reg <= 1'b0;
      mode_reg <= MODE_RNE;
      exp_reg  <= '0;
      rem_reg  <= '0;
      div_reg  <= '0;
      q_reg    <= '0;
      cnt_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            busy     <= 1'b1;
            sign_reg <= sign_in;
            mode_reg <= mode_in;
            if (special) begin
              state <= DONE;
              done  <= 1'b1;
              fp_Z  <= special_z;
              ovrf  <= 1'b0;
              udrf  <= 1'b0;
            end else begin
              state   <= DIV;
              exp_reg <= exp_init;
              rem_reg <= rem_init;
              div_reg <= my;
              q_reg   <= '0;
              cnt_reg <= '0;
            end
          end
        end
        DIV: begin
          rem_reg <= rem_step;
          q_reg   <= {q_reg[23:0], q_bit};
          cnt_reg <= cnt_reg + 5'd1;
          if (cnt_reg == 5'd25)
            state <= ROUND;
        end
        ROUND: begin
          fp_Z  <= round_z;
          ovrf  <= ovf;
          udrf  <= unf;
          done  <= 1'b1;
          state <= DONE;
        end
        DONE: begin
          done  <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fp_div_seq.sv
`timescale 1ns/1ps
// tb_fp_div_seq -- directed, table-driven bench for fp_div_seq.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst, start;
  logic [31:0] fp_X, fp_Y;
  logic [2:0]  r_mode;
  logic        busy, done, ovrf, udrf;
  logic [31:0] fp_Z;

  int total = 0;
  int bad   = 0;

  fp_div_seq dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .fp_X   (fp_X),
    .fp_Y   (fp_Y),
    .r_mode (r_mode),
    .busy   (busy),
    .done   (done),
    .fp_Z   (fp_Z),
    .ovrf   (ovrf),
    .udrf   (udrf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] x;
    logic [31:0] y;
    logic [2:0]  m;
    logic [31:0] z;
    logic        ov;
    logic        ud;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                     input logic [31:0] z, input logic ov, input logic ud, input int lat);
    vec_t v;
    v.x = x; v.y = y; v.m = m; v.z = z; v.ov = ov; v.ud = ud; v.lat = lat;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp_v);
    end
  endtask

  // Issues one operation and waits (bounded) for done. lat is the cycle
  // index at which done is seen: 1 = the cycle right after start is sampled.
  task automatic do_op(input logic [31:0] x, input logic [31:0] y, input logic [2:0] m,
                       output logic [31:0] z, output logic ov, output logic ud,
                       output int lat);
    int n;
    n = 0;
    @(negedge clk);
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    fp_X = x; fp_Y = y; r_mode = m; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    z = fp_Z; ov = ovrf; ud = udrf;
  endtask

  initial begin
    logic [31:0] z;
    logic        ov, ud, seen;
    int          lat, cyc;

    // Table: x, y, mode, expected z, ovrf, udrf, latency
    add(32'h3F800000, 32'h3F800000, 3'd0, 32'h3F800000, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd0, 32'h3EAAAAAB, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd1, 32'h3EAAAAAA, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd2, 32'h3EAAAAAA, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd3, 32'h3EAAAAAB, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd4, 32'h3EAAAAAB, 0, 0, 28);
    add(32'h3F800000, 32'h40400000, 3'd7, 32'h3EAAAAAB, 0, 0, 28);
    add(32'hBF800000, 32'h40400000, 3'd2, 32'hBEAAAAAB, 0, 0, 28);
    add(32'hBF800000, 32'h40400000, 3'd3, 32'hBEAAAAAA, 0, 0, 28);
    add(32'hBF800000, 32'h40400000, 3'd1, 32'hBEAAAAAA, 0, 0, 28);
    add(32'h40C00000, 32'h40000000, 3'd0, 32'h40400000, 0, 0, 28);
    add(32'h3F800000, 32'h3F800001, 3'd0, 32'h3F7FFFFE, 0, 0, 28);
    add(32'h3F800000, 32'h3F800001, 3'd3, 32'h3F7FFFFF, 0, 0, 28);
    add(32'h7F000000, 32'h00800000, 3'd0, 32'h7F800000, 1, 0, 28);
    add(32'h7F000000, 32'h00800000, 3'd1, 32'h7F7FFFFF, 1, 0, 28);
    add(32'h7F000000, 32'h00800000, 3'd3, 32'h7F800000, 1, 0, 28);
    add(32'h7F000000, 32'h00800000, 3'd2, 32'h7F7FFFFF, 1, 0, 28);
    add(32'hFF000000, 32'h00800000, 3'd2, 32'hFF800000, 1, 0, 28);
    add(32'hFF000000, 32'h00800000, 3'd3, 32'hFF7FFFFF, 1, 0, 28);
    add(32'h7F000000, 32'h00800000, 3'd4, 32'h7F800000, 1, 0, 28);
    add(32'h7F000000, 32'h3F800000, 3'd0, 32'h7F000000, 0, 0, 28);
    add(32'h7F000000, 32'h3F000000, 3'd0, 32'h7F800000, 1, 0, 28);
    add(32'h00800000, 32'h40000000, 3'd0, 32'h00000000, 0, 1, 28);
    add(32'h80800000, 32'h40000000, 3'd0, 32'h80000000, 0, 1, 28);
    add(32'h00800000, 32'h3F800000, 3'd0, 32'h00800000, 0, 0, 28);
    add(32'h80000000, 32'h3F800000, 3'd0, 32'h80000000, 0, 0, 1);
    add(32'h00000000, 32'h00000000, 3'd0, 32'h7FC00000, 0, 0, 1);
    add(32'h40000000, 32'h80000000, 3'd0, 32'hFF800000, 0, 0, 1);
    add(32'h7FC00001, 32'h3F800000, 3'd0, 32'h7FC00000, 0, 0, 1);
    add(32'h3F800000, 32'h7F800001, 3'd0, 32'h7FC00000, 0, 0, 1);
    add(32'h7F800000, 32'hFF800000, 3'd0, 32'h7FC00000, 0, 0, 1);
    add(32'h7F800000, 32'hC0000000, 3'd0, 32'hFF800000, 0, 0, 1);
    add(32'h3F800000, 32'hFF800000, 3'd0, 32'h80000000, 0, 0, 1);
    add(32'h00000001, 32'h3F800000, 3'd0, 32'h00000000, 0, 0, 1);
    add(32'h3F800000, 32'h00000001, 3'd0, 32'h7F800000, 0, 0, 1);
    add(32'hC0000000, 32'h00400000, 3'd0, 32'hFF800000, 0, 0, 1);

    rst = 1'b1; start = 1'b0; fp_X = '0; fp_Y = '0; r_mode = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ctrl", {28'd0, busy, done, ovrf, udrf}, 32'd0);
    chk("reset_z", fp_Z, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      do_op(vecs[i].x, vecs[i].y, vecs[i].m, z, ov, ud, lat);
      $display("vec %0d: %h / %h mode %0d -> %h ov=%0b ud=%0b lat=%0d",
               i, vecs[i].x, vecs[i].y, vecs[i].m, z, ov, ud, lat);
      chk($sformatf("v%0d_z", i), z, vecs[i].z);
      chk($sformatf("v%0d_flags", i), {30'd0, ov, ud}, {30'd0, vecs[i].ov, vecs[i].ud});
      chk($sformatf("v%0d_lat", i), lat, vecs[i].lat);
      // One-cycle done pulse, back to idle, result held.
      @(posedge clk); #1;
      chk($sformatf("v%0d_after", i), {30'd0, done, busy}, 32'd0);
      chk($sformatf("v%0d_hold", i), fp_Z, vecs[i].z);
    end

    // Reset in the middle of a divide, restart, and an ignored start.
    @(negedge clk);
    fp_X = 32'h3F800000; fp_Y = 32'h40400000; r_mode = 3'd0; start = 1'b1;
    @(posedge clk); #1;               // start sampled; now in cycle +1
    start = 1'b0;
    seen = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      @(posedge clk); #1;
      seen |= done;
    end
    rst = 1'b1;                        // sampled at the end of cycle +10
    @(posedge clk); #1;
    rst = 1'b0;
    chk("rst_abort_ctrl", {30'd0, busy, done}, 32'd0);
    chk("rst_clears_z", fp_Z, 32'd0);
    @(posedge clk); #1;               // cycle +12
    seen |= done;
    fp_X = 32'h40C00000; fp_Y = 32'h40000000; r_mode = 3'd0; start = 1'b1;
    @(posedge clk); #1;               // cycle +13
    start = 1'b0;
    cyc = 13;
    chk("restart_busy", {31'd0, busy}, 32'd1);
    while (!done && cyc < 80) begin
      if (cyc == 20) begin
        fp_X = 32'h3F800000; fp_Y = 32'h3F800000; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    $display("restart: done at +%0d z=%h ov=%0b ud=%0b", cyc, fp_Z, ovrf, udrf);
    chk("aborted_no_done", {31'd0, seen}, 32'd0);
    chk("restart_cycle", cyc, 32'd40);
    chk("restart_z", fp_Z, 32'h40400000);
    chk("restart_flags", {30'd0, ovrf, udrf}, 32'd0);
    seen = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      seen |= done | busy;
    end
    chk("ignored_start", {31'd0, seen}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fp_div_seq.md
FP_DIV_SEQ -- requirements
Module: fp_div_seq

Interface
- No parameters.
- REQ-001: clk  input  1  single clock; all state updates on rising edge.
- REQ-002: rst  input  1  reset, synchronous, active-high.
- REQ-003: start  input  1  request; sampled only while busy=0.
- REQ-004: fp_X  input  32  dividend, IEEE-754 single.
- REQ-005: fp_Y  input  32  divisor, IEEE-754 single.
- REQ-006: r_mode  input  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101-111 treated as RNE.
- REQ-007: busy  output  1  operation in progress.
- REQ-008: done  output  1  one-cycle pulse; fp_Z/ovrf/udrf valid.
- REQ-009: fp_Z  output  32  quotient fp_X / fp_Y.
- REQ-010: ovrf  output  1  overflow flag for this result.
- REQ-011: udrf  output  1  underflow flag for this result.

Function
- REQ-012: States SHALL be IDLE, DIV, ROUND, DONE.
- REQ-013: IDLE with start=1 SHALL latch fp_X, fp_Y, r_mode and set busy=1 next cycle; start while busy=1 SHALL be ignored.
- REQ-014: Operand classes:
  - exponent 00 = zero (subnormals flushed to signed zero);
  - exponent FF with fraction 0 = inf;
  - exponent FF with fraction !=0 = NaN.
- REQ-015: Special cases SHALL go IDLE->DONE, with done at start cycle +1:
  - any NaN, 0/0 or inf/inf -> 7FC00000;
  - x/0 (x nonzero) or inf/finite -> signed inf;
  - 0/y or finite/inf -> signed zero;
  - flags 0.
- REQ-016: Sign = sign(X) XOR sign(Y).
- REQ-017: Biased exponent = eX - eY + 127, computed in 10-bit signed.
- REQ-018: Mantissas are {1,frac}. If mX < mY, the dividend SHALL be doubled and the exponent decremented, so the quotient lies in [1,2).
- REQ-019: DIV SHALL run exactly 26 restoring iterations, one quotient bit per cycle: 24 mantissa bits, then guard, then round. Sticky = final remainder != 0.
- REQ-020: ROUND (1 cycle) SHALL apply r_mode to guard/round/sticky and sign. Mantissa carry-out SHALL renormalise to 1.0 with exponent +1.
- REQ-021: Normal-operand latency SHALL be fixed: DIV cycles +1..+26, ROUND +27, DONE (done=1) +28, then IDLE.
- REQ-022: Exponent >= 255 after rounding SHALL set ovrf=1. Result:
  - inf for RNE/RMM;
  - max finite (7F7FFFFF with sign) for RTZ;
  - inf if the sign is favoured by the mode, else max finite, for RDN/RUP.
- REQ-023: Exponent <= 0 after rounding SHALL give signed zero with udrf=1 (no subnormal output).
- REQ-024: fp_Z, ovrf and udrf SHALL hold their last values from DONE until the next DONE.
- REQ-025: busy=1 in DIV, ROUND and DONE; busy=0 in IDLE. done=1 only in DONE.

Reset
- REQ-026: rst=1 SHALL, on the next edge, force IDLE and set busy=0, done=0, fp_Z=0, ovrf=0, udrf=0.
- REQ-027: Reset mid-operation SHALL abort with no done pulse; a start in the first cycle after rst deasserts SHALL be accepted.
- REQ-028: rst SHALL have priority over start.

Verification
- REQ-029: 3F800000/3F800000, RNE -> fp_Z=3F800000, flags 0, done exactly 28 cycles after start.
- REQ-030: 3F800000/40400000 -> RNE 3EAAAAAB; RTZ 3EAAAAAA.
- REQ-031: 7F000000/00800000 -> RNE 7F800000 with ovrf=1; RTZ 7F7FFFFF with ovrf=1.
- REQ-032: 00800000/40000000 -> 00000000 with udrf=1; 80000000/3F800000 -> 80000000 with flags 0, done at +1.
- REQ-033: 00000000/00000000 -> 7FC00000; 40000000/80000000 -> FF800000; both with done at +1.
- REQ-034: rst at cycle +10 of a normal divide -> no done, busy=0; a new start at +12 (rst low) completes correctly at +40, and a start pulse during busy is ignored.
